// File: rtl/serializer_if.sv
// Parallel-in / serial-out bus of the serializer, grouped as one interface.
// The slave modport is the serializer side; the master modport is the producer/consumer side.
interface serializer_if #(
   parameter int DATA_W = 16,
   parameter int MOD_W  = $clog2(DATA_W)
);
   logic [DATA_W-1:0] data_i;
   logic [MOD_W-1:0]  data_mod_i;
   logic              data_val_i;
   logic              ready_o;
   logic              ser_data_o;
   logic              ser_data_val_o;
   logic              busy_o;

   modport slave (
      input  data_i, data_mod_i, data_val_i,
      output ready_o, ser_data_o, ser_data_val_o, busy_o
   );

   modport master (
      output data_i, data_mod_i, data_val_i,
      input  ready_o, ser_data_o, ser_data_val_o, busy_o
   );
endinterface

// File: rtl/serializer.sv
// Parallel-to-serial converter, MSB-first, bit count per word (0 = DATA_W, 1/2 dropped).
// Define SERIALIZER_PREFETCH_EN to add a one-word prefetch register for gapless back-to-back words.
module serializer #(
   parameter int DATA_W = 16,
   parameter int MOD_W  = $clog2(DATA_W)
) (
   input  logic          clk_i,
   input  logic          arst_ni,
   serializer_if.slave   bus
);
   localparam int CNT_W = MOD_W + 1;
   localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(DATA_W);

   typedef enum logic {IDLE, SHIFT} state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   shreg_q, shreg_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                busy_q, busy_d;
   logic                ser_data_q, ser_data_d;
   logic                ready_q, ready_d;

   logic                mod_ok;
   logic                accept;
   logic [CNT_W-1:0]    len_in;
   logic                load;
   logic [DATA_W-1:0]   load_word;
   logic [CNT_W-1:0]    load_len;

`ifdef SERIALIZER_PREFETCH_EN
   logic [DATA_W-1:0]   pf_data_q, pf_data_d;
   logic [CNT_W-1:0]    pf_len_q, pf_len_d;
   logic                pf_full_q, pf_full_d;
`endif

   assign mod_ok = !((bus.data_mod_i == MOD_W'(1)) || (bus.data_mod_i == MOD_W'(2)));
   assign accept = bus.data_val_i & ready_q & mod_ok;
   assign len_in = (bus.data_mod_i == '0) ? FULL_LEN : {1'b0, bus.data_mod_i};

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      cnt_d      = cnt_q;
      busy_d     = busy_q;
      ser_data_d = ser_data_q;
      load       = 1'b0;
      load_word  = bus.data_i;
      load_len   = len_in;
`ifdef SERIALIZER_PREFETCH_EN
      pf_data_d  = pf_data_q;
      pf_len_d   = pf_len_q;
      pf_full_d  = pf_full_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) load = 1'b1;
         end
         SHIFT: begin
            if (cnt_q > CNT_W'(1)) begin
               ser_data_d = shreg_q[DATA_W-1];
               shreg_d    = {shreg_q[DATA_W-2:0], 1'b0};
               cnt_d      = cnt_q - CNT_W'(1);
`ifdef SERIALIZER_PREFETCH_EN
               if (accept) begin
                  pf_data_d = bus.data_i;
                  pf_len_d  = len_in;
                  pf_full_d = 1'b1;
               end
`endif
            end else begin
`ifdef SERIALIZER_PREFETCH_EN
               // Last bit: chain the pending word so its first bit follows with no gap.
               if (pf_full_q) begin
                  load      = 1'b1;
                  load_word = pf_data_q;
                  load_len  = pf_len_q;
                  pf_full_d = 1'b0;
               end else if (accept) begin
                  load = 1'b1;
               end
`endif
               if (!load) begin
                  state_d    = IDLE;
                  busy_d     = 1'b0;
                  ser_data_d = 1'b0;
                  cnt_d      = '0;
                  shreg_d    = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // The first bit is presented straight from the load so latency is one cycle.
      if (load) begin
         state_d    = SHIFT;
         busy_d     = 1'b1;
         ser_data_d = load_word[DATA_W-1];
         shreg_d    = {load_word[DATA_W-2:0], 1'b0};
         cnt_d      = load_len;
      end

`ifdef SERIALIZER_PREFETCH_EN
      ready_d = !pf_full_d;
`else
      ready_d = !busy_d;
`endif
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         ser_data_q <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         ser_data_q <= ser_data_d;
         ready_q    <= ready_d;
      end
   end

`ifdef SERIALIZER_PREFETCH_EN
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         pf_data_q <= '0;
         pf_len_q  <= '0;
         pf_full_q <= 1'b0;
      end else begin
         pf_data_q <= pf_data_d;
         pf_len_q  <= pf_len_d;
         pf_full_q <= pf_full_d;
      end
   end
`endif

   assign bus.ready_o        = ready_q;
   assign bus.ser_data_o     = ser_data_q;
   assign bus.ser_data_val_o = busy_q;
   assign bus.busy_o         = busy_q;
endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: directed scenarios plus randomized streams
// compared against a word-level bit-stream model and a behavioural 16-bit deserializer.
module tb_serializer;
   localparam int DW = 16;
   localparam int MW = 4;

   typedef bit bitq_t[$];

   logic clk = 1'b0;
   logic arst_ni;
   always #5 clk = ~clk;

   serializer_if #(.DATA_W(DW), .MOD_W(MW)) bus();
   serializer #(.DATA_W(DW), .MOD_W(MW)) dut (
      .clk_i   (clk),
      .arst_ni (arst_ni),
      .bus     (bus)
   );

   int total = 0;
   int bad   = 0;

   // Reference: the bits a word should produce, in emission order.
   function automatic bitq_t ref_bits(input logic [15:0] w, input logic [3:0] m);
      bitq_t q;
      int    len;
      q = {};
      if (m == 4'd1 || m == 4'd2) return q;
      len = (m == 4'd0) ? DW : int'(m);
      for (int k = 0; k < len; k++) q.push_back(w[DW-1-k]);
      return q;
   endfunction

   task automatic idle_inputs();
      bus.data_val_i = 1'b0;
      bus.data_i     = 16'($urandom);
      bus.data_mod_i = 4'd0;
   endtask

   // Drives one word and returns after its acceptance edge (#1 past it), then scrambles inputs.
   task automatic send(input logic [15:0] d, input logic [3:0] m, output bit ok);
      @(negedge clk);
      bus.data_i = d; bus.data_mod_i = m; bus.data_val_i = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (bus.ready_o === 1'b1) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      @(posedge clk); #1;
      bus.data_val_i = 1'b0;
      bus.data_i     = 16'($urandom);
      bus.data_mod_i = 4'($urandom);
   endtask

   task automatic test_reset();
      idle_inputs();
      arst_ni = 1'b1;
      #3 arst_ni = 1'b0;
      #1;
      total++; if (bus.ser_data_val_o !== 1'b0) begin bad++; $display("FAIL reset_val: got %b want 0", bus.ser_data_val_o); end
      total++; if (bus.ser_data_o !== 1'b0) begin bad++; $display("FAIL reset_data: got %b want 0", bus.ser_data_o); end
      total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
      total++; if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", bus.ready_o); end
      repeat (3) @(posedge clk);
      @(negedge clk); arst_ni = 1'b1; #1;
      total++; if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL ready_before_edge: got %b want 0", bus.ready_o); end
      @(posedge clk); #1;
      total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL ready_after_release: got %b want 1", bus.ready_o); end
   endtask

   task automatic test_full_word();
      bitq_t exp;
      bit    ok;
      exp = ref_bits(16'hA5C3, 4'd0);
      send(16'hA5C3, 4'd0, ok);
      total++; if (!ok) begin bad++; $display("FAIL a5c3_accept: got not-ready want ready"); end
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         total++;
         if (bus.ser_data_val_o !== 1'b1 || bus.ser_data_o !== exp[k] || bus.busy_o !== 1'b1) begin
            bad++;
            $display("FAIL a5c3_bit%0d: got val=%b data=%b busy=%b want val=1 data=%b busy=1",
                     k, bus.ser_data_val_o, bus.ser_data_o, bus.busy_o, exp[k]);
         end
      end
      @(negedge clk);
      total++;
      if (bus.ser_data_val_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.ser_data_o !== 1'b0) begin
         bad++;
         $display("FAIL a5c3_end: got val=%b busy=%b data=%b want 0 0 0", bus.ser_data_val_o, bus.busy_o, bus.ser_data_o);
      end
   endtask

   task automatic test_reset_mid_word();
      bit ok;
      int hits;
      send(16'($urandom) | 16'h8000, 4'd0, ok);
      repeat (6) @(negedge clk);
      arst_ni = 1'b0; #1;
      total++;
      if (bus.ser_data_val_o !== 1'b0 || bus.ser_data_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0) begin
         bad++;
         $display("FAIL midword_reset: got val=%b data=%b busy=%b ready=%b want all 0",
                  bus.ser_data_val_o, bus.ser_data_o, bus.busy_o, bus.ready_o);
      end
      repeat (2) @(posedge clk);
      @(negedge clk); arst_ni = 1'b1;
      hits = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.ser_data_val_o !== 1'b0 || bus.busy_o !== 1'b0) hits++;
      end
      total++; if (hits != 0) begin bad++; $display("FAIL midword_continuation: got %0d active cycles want 0", hits); end
      total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL midword_ready: got %b want 1", bus.ready_o); end
   endtask

   task automatic test_short_word();
      bitq_t exp;
      bit    ok;
      int    hits;
      exp = ref_bits(16'hF000, 4'd4);
      send(16'hF000, 4'd4, ok);
      for (int k = 0; k < exp.size(); k++) begin
         @(negedge clk);
         total++;
         if (bus.ser_data_val_o !== 1'b1 || bus.ser_data_o !== exp[k]) begin
            bad++;
            $display("FAIL short_bit%0d: got val=%b data=%b want val=1 data=%b", k, bus.ser_data_val_o, bus.ser_data_o, exp[k]);
         end
      end
      hits = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.ser_data_val_o !== 1'b0 || bus.ser_data_o !== 1'b0) hits++;
      end
      total++; if (hits != 0) begin bad++; $display("FAIL short_tail: got %0d extra valid cycles want 0", hits); end
   endtask

   task automatic test_illegal_mod();
      int hits, rdy_low;
      for (int m = 1; m <= 2; m++) begin
         @(negedge clk);
         bus.data_i = 16'($urandom) | 16'h8000; bus.data_mod_i = 4'(m); bus.data_val_i = 1'b1;
         @(posedge clk); #1;
         bus.data_val_i = 1'b0;
         hits = 0; rdy_low = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.ser_data_val_o !== 1'b0 || bus.busy_o !== 1'b0) hits++;
            if (bus.ready_o !== 1'b1) rdy_low++;
         end
         total++; if (hits != 0) begin bad++; $display("FAIL illegal_mod%0d_output: got %0d valid cycles want 0", m, hits); end
         total++; if (rdy_low != 0) begin bad++; $display("FAIL illegal_mod%0d_ready: got %0d not-ready cycles want 0", m, rdy_low); end
      end
   endtask

   task automatic test_back_to_back();
      bit lv[$], ld[$], lr[$];
      int acc_idx, nacc, f;
      bit acc;
      lv = {}; ld = {}; lr = {};
      acc_idx = -1; nacc = 0;
      @(negedge clk);
      bus.data_i = 16'hFFFF; bus.data_mod_i = 4'd0; bus.data_val_i = 1'b1;
      for (int c = 0; c < 60; c++) begin
         lv.push_back(bus.ser_data_val_o); ld.push_back(bus.ser_data_o); lr.push_back(bus.ready_o);
         acc = (bus.data_val_i === 1'b1) && (bus.ready_o === 1'b1);
         if (acc && nacc == 0) acc_idx = c;
         @(posedge clk); #1;
         if (acc) begin
            nacc++;
            if (nacc == 1) bus.data_i = 16'h0000;
            else begin bus.data_val_i = 1'b0; bus.data_i = 16'($urandom); end
         end
         @(negedge clk);
      end
      bus.data_val_i = 1'b0;
      total++; if (nacc != 2) begin bad++; $display("FAIL b2b_accepts: got %0d want 2", nacc); end
      f = acc_idx + 1;
      total++;
      if (acc_idx < 0 || f + 34 > 60) begin
         bad++; $display("FAIL b2b_first_accept: got index %0d want 0..25", acc_idx);
         return;
      end
`ifdef SERIALIZER_PREFETCH_EN
      for (int k = 0; k < 32; k++) begin
         total++;
         if (lv[f+k] !== 1'b1 || ld[f+k] !== (k < 16)) begin
            bad++; $display("FAIL b2b_bit%0d: got val=%b data=%b want val=1 data=%b", k, lv[f+k], ld[f+k], (k < 16));
         end
      end
      total++; if (lv[f+32] !== 1'b0) begin bad++; $display("FAIL b2b_end: got val=%b want 0", lv[f+32]); end
      total++; if (lr[f+1] !== 1'b0 || lr[f+15] !== 1'b0) begin bad++; $display("FAIL b2b_ready_pending: got %b%b want 00", lr[f+1], lr[f+15]); end
      total++; if (lr[f+16] !== 1'b1) begin bad++; $display("FAIL b2b_ready_rise: got %b want 1", lr[f+16]); end
`else
      for (int k = 0; k < 16; k++) begin
         total++;
         if (lv[f+k] !== 1'b1 || ld[f+k] !== 1'b1) begin
            bad++; $display("FAIL b2b_w0_bit%0d: got val=%b data=%b want 1 1", k, lv[f+k], ld[f+k]);
         end
      end
      total++; if (lv[f+16] !== 1'b0 || lr[f+16] !== 1'b1) begin bad++; $display("FAIL b2b_gap: got val=%b ready=%b want 0 1", lv[f+16], lr[f+16]); end
      for (int k = 0; k < 16; k++) begin
         total++;
         if (lv[f+17+k] !== 1'b1 || ld[f+17+k] !== 1'b0) begin
            bad++; $display("FAIL b2b_w1_bit%0d: got val=%b data=%b want 1 0", k, lv[f+17+k], ld[f+17+k]);
         end
      end
      total++; if (lv[f+33] !== 1'b0) begin bad++; $display("FAIL b2b_end: got val=%b want 0", lv[f+33]); end
`endif
   endtask

   // Random words through a serializer-driven stream; mods random (with illegal ones) or all full-width.
   task automatic test_random_stream(input int n, input bit full_only);
      logic [15:0] words[$];
      logic [3:0]  mods[$];
      bitq_t       exp, rx, t;
      logic [15:0] wq[$], acc_w;
      int idx, quiet, zero_viol, nb, bad_words;
      bit drv, acc;
      words = {}; mods = {}; exp = {}; rx = {}; wq = {};
      for (int i = 0; i < n; i++) begin
         words.push_back(16'($urandom));
         if (full_only) mods.push_back(4'd0);
         else mods.push_back(4'($urandom_range(15, 0)));
      end
      idx = 0; quiet = 0; zero_viol = 0; drv = 1'b0;
      @(negedge clk);
      for (int c = 0; c < 3000; c++) begin
         if (bus.ser_data_val_o === 1'b1) rx.push_back(bus.ser_data_o);
         else if (bus.ser_data_o !== 1'b0) zero_viol++;
         if (!drv && idx < n && $urandom_range(3, 0) != 0) begin
            bus.data_i = words[idx]; bus.data_mod_i = mods[idx]; bus.data_val_i = 1'b1; drv = 1'b1;
         end
         acc = drv && (bus.ready_o === 1'b1);
         @(posedge clk); #1;
         if (acc) begin
            t = ref_bits(words[idx], mods[idx]);
            foreach (t[i]) exp.push_back(t[i]);
            idx++; drv = 1'b0;
            bus.data_val_i = 1'b0; bus.data_i = 16'($urandom); bus.data_mod_i = 4'($urandom);
         end
         @(negedge clk);
         if (idx == n) quiet++;
         if (quiet > 40) break;
      end
      bus.data_val_i = 1'b0;
      total++; if (idx != n) begin bad++; $display("FAIL stream_timeout: got %0d accepted want %0d", idx, n); end
      total++; if (zero_viol != 0) begin bad++; $display("FAIL stream_idle_data: got %0d nonzero idle bits want 0", zero_viol); end
      total++; if (rx.size() != exp.size()) begin bad++; $display("FAIL stream_bitcount: got %0d want %0d", rx.size(), exp.size()); end
      nb = (rx.size() < exp.size()) ? rx.size() : exp.size();
      total++;
      for (int i = 0; i < nb; i++) begin
         if (rx[i] !== exp[i]) begin
            bad++; $display("FAIL stream_bit%0d: got %b want %b", i, rx[i], exp[i]);
            break;
         end
      end
      if (full_only) begin
         // Behavioural 16-bit deserializer on the received stream.
         acc_w = '0;
         for (int i = 0; i < rx.size(); i++) begin
            acc_w = {acc_w[14:0], rx[i]};
            if (i % 16 == 15) wq.push_back(acc_w);
         end
         total++; if (wq.size() != n) begin bad++; $display("FAIL e2e_wordcount: got %0d want %0d", wq.size(), n); end
         bad_words = 0;
         for (int i = 0; i < wq.size() && i < n; i++) if (wq[i] !== words[i]) bad_words++;
         total++; if (bad_words != 0) begin bad++; $display("FAIL e2e_words: got %0d mismatched words want 0", bad_words); end
      end
   endtask

   initial begin
      test_reset();
      test_full_word();
      test_short_word();
      test_illegal_mod();
      test_back_to_back();
      test_random_stream(24, 1'b0);
      test_random_stream(12, 1'b1);
      test_reset_mid_word();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
